frogg_game_ctrl: RTL and testbench
==================================

FROGG_GAME_CTRL -- requirements
Module: frogg_game_ctrl

Interface
REQ-001 SHALL have parameter c_GAME_HEIGHT, default 30, playfield height in rows.
REQ-002 SHALL have parameter c_START_LIVES, default 3, lives loaded at game start (range 1..7).
REQ-003 SHALL have parameter c_HOLD_CYCLES, default 25000000, freeze duration after hit or goal (>=2).
REQ-004 SHALL have parameter c_MAX_LEVEL, default 15, level saturation value (<=15).
REQ-005 SHALL have port i_Clk, input, 1, the only clock.
REQ-006 SHALL have port i_Rst, input, 1, reset; synchronous, active-high.
REQ-007 SHALL have port i_Start, input, 1, start button level.
REQ-008 SHALL have port i_Frog_Y, input, 6, frog row from the frog controller (0 = top/goal row).
REQ-009 SHALL have port i_Collision, input, 1, frog/obstacle overlap level.
REQ-010 SHALL have port o_Game_Active, output, 1, enables frog movement and obstacle motion.
REQ-011 SHALL have port o_Frog_Reset, output, 1, one-cycle pulse returning the frog to its start position.
REQ-012 SHALL have port o_Lives, output, 3, remaining lives.
REQ-013 SHALL have port o_Level, output, 4, current level.
REQ-014 SHALL have port o_Score, output, 8, goals reached.
REQ-015 SHALL have port o_State, output, 3, state encoding: IDLE=0, PLAY=1, HIT=2, GOAL=3, OVER=4.

Function
REQ-016 All outputs SHALL be registered; every state change takes effect on the i_Clk edge after the qualifying input is sampled.
REQ-017 Start detection SHALL be a rising edge: i_Start=1 this cycle and 0 in the previous cycle, using a one-register history.
REQ-018 IDLE or OVER + start edge -> PLAY; same edge loads o_Lives=c_START_LIVES, o_Level=1, o_Score=0, o_Frog_Reset=1.
REQ-019 PLAY + i_Collision=1 -> HIT; o_Lives decrements by 1 on the same edge.
REQ-020 PLAY + i_Collision=0 + i_Frog_Y==0 -> GOAL; o_Score increments, saturating at 255; o_Level increments, saturating at c_MAX_LEVEL.
REQ-021 If collision and goal occur in the same cycle, collision SHALL win: HIT only, no score or level change.
REQ-022 HIT and GOAL SHALL each last exactly c_HOLD_CYCLES cycles, timed by a hold counter cleared on entry.
REQ-023 On HIT expiry: o_Lives==0 -> OVER with no frog reset; otherwise -> PLAY with o_Frog_Reset=1 for one cycle.
REQ-024 On GOAL expiry: -> PLAY with o_Frog_Reset=1 for one cycle.
REQ-025 o_Game_Active SHALL be 1 only while in PLAY.
REQ-026 i_Collision and i_Frog_Y SHALL be ignored outside PLAY; start edges SHALL be ignored outside IDLE and OVER.
REQ-027 o_Lives SHALL never underflow; the decrement occurs only on a PLAY->HIT transition.
REQ-028 Score, level and lives SHALL hold their values in OVER until the next start edge.
REQ-029 o_Frog_Reset SHALL be 0 in every cycle other than those specified in REQ-018, REQ-023 and REQ-024.

Reset
REQ-030 i_Rst=1 SHALL force IDLE, o_Game_Active=0, o_Frog_Reset=0, o_Lives=0, o_Level=0, o_Score=0, and clear the hold counter.
REQ-031 Reset SHALL set the start-history register to 1, so a button held through reset does not start a game.
REQ-032 Reset asserted in any state, including mid-hold, SHALL take priority over all transitions in that cycle.

Verification (c_HOLD_CYCLES=4, c_START_LIVES=3)
REQ-033 Start: reset, then pulse i_Start -> next edge o_State=1, o_Lives=3, o_Level=1, o_Score=0, one-cycle o_Frog_Reset, o_Game_Active=1.
REQ-034 Goal: in PLAY set i_Frog_Y=0 -> o_State=3, o_Score=1, o_Level=2, o_Game_Active=0 for 4 cycles, then PLAY with one o_Frog_Reset pulse.
REQ-035 Game over: three collisions, each followed by 4-cycle HIT -> o_Lives 2,1,0; after the third hold o_State=4 with no frog reset pulse; further collisions leave state unchanged.
REQ-036 Simultaneous events: i_Collision=1 and i_Frog_Y=0 in the same PLAY cycle -> HIT, o_Lives decremented, o_Score unchanged.
REQ-037 Held start: hold i_Start=1 through and after reset -> stays IDLE; release then press -> PLAY.
REQ-038 Reset mid-HIT: assert i_Rst during HIT cycle 2 -> next edge IDLE, all counters 0, no o_Frog_Reset pulse.

Source files
------------

// File: rtl/frogg_game_if.sv
// Signal bundle between the frog game controller and the rest of the game:
// start/frog/collision status in, game state and counters out.
interface frogg_game_if;
  logic       i_Start;
  logic [5:0] i_Frog_Y;
  logic       i_Collision;
  logic       o_Game_Active;
  logic       o_Frog_Reset;
  logic [2:0] o_Lives;
  logic [3:0] o_Level;
  logic [7:0] o_Score;
  logic [2:0] o_State;

  modport master (
    output i_Start, i_Frog_Y, i_Collision,
    input  o_Game_Active, o_Frog_Reset, o_Lives, o_Level, o_Score, o_State
  );

  modport slave (
    input  i_Start, i_Frog_Y, i_Collision,
    output o_Game_Active, o_Frog_Reset, o_Lives, o_Level, o_Score, o_State
  );
endinterface

// File: rtl/frogg_game_ctrl.sv
// Frogger game flow controller: start, play, hit/goal freeze, game over.
// Tracks lives, level and score and pulses a frog reset when a round restarts.
module frogg_game_ctrl #(
  parameter int c_GAME_HEIGHT = 30,
  parameter int c_START_LIVES = 3,
  parameter int c_HOLD_CYCLES = 25000000,
  parameter int c_MAX_LEVEL   = 15
) (
  input logic         i_Clk,
  input logic         i_Rst,
  frogg_game_if.slave game
);

  localparam int c_HOLD_W = $clog2(c_HOLD_CYCLES);
  localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(c_HOLD_CYCLES - 1);

  generate
    if (c_START_LIVES < 1 || c_START_LIVES > 7 || c_HOLD_CYCLES < 2 ||
        c_MAX_LEVEL < 1 || c_MAX_LEVEL > 15 ||
        c_GAME_HEIGHT < 2 || c_GAME_HEIGHT > 64) begin : g_bad_params
      $error("frogg_game_ctrl: parameter out of range");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PLAY = 3'd1,
    HIT  = 3'd2,
    GOAL = 3'd3,
    OVER = 3'd4
  } state_t;

  state_t              state_reg;
  logic [c_HOLD_W-1:0] hold_cnt_reg;
  logic                start_prev_reg;
  logic                game_active_reg;
  logic                frog_reset_reg;
  logic [2:0]          lives_reg;
  logic [3:0]          level_reg;
  logic [7:0]          score_reg;
  logic                start_edge;

  assign start_edge = game.i_Start & ~start_prev_reg;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_reg       <= IDLE;
      hold_cnt_reg    <= '0;
      start_prev_reg  <= 1'b1;  // a button held through reset must not start a game
      game_active_reg <= 1'b0;
      frog_reset_reg  <= 1'b0;
      lives_reg       <= 3'd0;
      level_reg       <= 4'd0;
      score_reg       <= 8'd0;
    end else begin
      start_prev_reg <= game.i_Start;
      frog_reset_reg <= 1'b0;
      case (state_reg)
        IDLE, OVER: begin
          if (start_edge) begin
            state_reg       <= PLAY;
            game_active_reg <= 1'b1;
            frog_reset_reg  <= 1'b1;
            lives_reg       <= 3'(c_START_LIVES);
            level_reg       <= 4'd1;
            score_reg       <= 8'd0;
          end
        end
        PLAY: begin
          // collision outranks reaching the goal row in the same cycle
          if (game.i_Collision) begin
            state_reg       <= HIT;
            game_active_reg <= 1'b0;
            hold_cnt_reg    <= '0;
            lives_reg       <= (lives_reg != 3'd0) ? lives_reg - 3'd1 : 3'd0;
          end else if (game.i_Frog_Y == 6'd0) begin
            state_reg       <= GOAL;
            game_active_reg <= 1'b0;
            hold_cnt_reg    <= '0;
            if (score_reg != 8'hFF) score_reg <= score_reg + 8'd1;
            if (level_reg < 4'(c_MAX_LEVEL)) level_reg <= level_reg + 4'd1;
          end
        end
        HIT, GOAL: begin
          if (hold_cnt_reg == c_HOLD_LAST) begin
            hold_cnt_reg <= '0;
            if (state_reg == HIT && lives_reg == 3'd0) begin
              state_reg <= OVER;
            end else begin
              state_reg       <= PLAY;
              game_active_reg <= 1'b1;
              frog_reset_reg  <= 1'b1;
            end
          end else begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg       <= IDLE;
          game_active_reg <= 1'b0;
        end
      endcase
    end
  end

  assign game.o_State       = state_reg;
  assign game.o_Game_Active = game_active_reg;
  assign game.o_Frog_Reset  = frog_reset_reg;
  assign game.o_Lives       = lives_reg;
  assign game.o_Level       = level_reg;
  assign game.o_Score       = score_reg;

endmodule

// File: tb/tb_frogg_game_ctrl.sv
// Bench for frogg_game_ctrl: directed scenarios with literal expectations,
// then randomized play, all checked every cycle against a behavioural model.
module tb_frogg_game_ctrl;

  localparam int HOLD    = 4;
  localparam int LIVES0  = 3;
  localparam int MAXLVL  = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  frogg_game_if game ();

  always #5 clk = ~clk;

  frogg_game_ctrl #(
    .c_GAME_HEIGHT(30),
    .c_START_LIVES(LIVES0),
    .c_HOLD_CYCLES(HOLD),
    .c_MAX_LEVEL(MAXLVL)
  ) dut (
    .i_Clk(clk),
    .i_Rst(rst),
    .game (game.slave)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: state as a plain number, hold timed as cycles remaining.
  int m_state, m_lives, m_level, m_score, m_left, m_fr, m_prev;
  bit m_edge;

  always @(posedge clk) begin
    if (rst) begin
      m_state = 0; m_lives = 0; m_level = 0; m_score = 0;
      m_left = 0; m_fr = 0; m_prev = 1;
    end else begin
      m_edge = game.i_Start && (m_prev == 0);
      m_prev = game.i_Start;
      m_fr = 0;
      if (m_state == 0 || m_state == 4) begin
        if (m_edge) begin
          m_state = 1; m_lives = LIVES0; m_level = 1; m_score = 0; m_fr = 1;
        end
      end else if (m_state == 1) begin
        if (game.i_Collision) begin
          m_state = 2; m_left = HOLD;
          if (m_lives > 0) m_lives = m_lives - 1;
        end else if (game.i_Frog_Y == 0) begin
          m_state = 3; m_left = HOLD;
          m_score = (m_score < 255) ? m_score + 1 : 255;
          m_level = (m_level < MAXLVL) ? m_level + 1 : MAXLVL;
        end
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          if (m_state == 2 && m_lives == 0) m_state = 4;
          else begin m_state = 1; m_fr = 1; end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("state",       int'(game.o_State),       m_state);
      chk("lives",       int'(game.o_Lives),       m_lives);
      chk("level",       int'(game.o_Level),       m_level);
      chk("score",       int'(game.o_Score),       m_score);
      chk("frog_reset",  int'(game.o_Frog_Reset),  m_fr);
      chk("game_active", int'(game.o_Game_Active), (m_state == 1) ? 1 : 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic txn(input string name);
    $display("txn %-12s state=%0d lives=%0d level=%0d score=%0d frog_reset=%0d active=%0d",
             name, game.o_State, game.o_Lives, game.o_Level, game.o_Score,
             game.o_Frog_Reset, game.o_Game_Active);
  endtask

  initial begin
    game.i_Start = 1'b0; game.i_Frog_Y = 6'd15; game.i_Collision = 1'b0;
    rst = 1'b1;
    tick(3);
    cmp_en = 1'b1;
    chk("rst_state", int'(game.o_State), 0);
    chk("rst_lives", int'(game.o_Lives), 0);
    chk("rst_score", int'(game.o_Score), 0);
    txn("reset");
    rst = 1'b0;
    tick(2);

    // start
    game.i_Start = 1'b1; tick(1);
    chk("start_state", int'(game.o_State), 1);
    chk("start_lives", int'(game.o_Lives), 3);
    chk("start_level", int'(game.o_Level), 1);
    chk("start_fr",    int'(game.o_Frog_Reset), 1);
    chk("start_act",   int'(game.o_Game_Active), 1);
    txn("start");
    game.i_Start = 1'b0; tick(1);
    chk("start_fr_off", int'(game.o_Frog_Reset), 0);

    // goal
    game.i_Frog_Y = 6'd0; tick(1);
    game.i_Frog_Y = 6'd10;
    chk("goal_state", int'(game.o_State), 3);
    chk("goal_score", int'(game.o_Score), 1);
    chk("goal_level", int'(game.o_Level), 2);
    chk("goal_act",   int'(game.o_Game_Active), 0);
    txn("goal");
    for (int i = 0; i < HOLD - 1; i++) begin
      tick(1);
      chk("goal_hold", int'(game.o_State), 3);
    end
    tick(1);
    chk("goal_exit_state", int'(game.o_State), 1);
    chk("goal_exit_fr",    int'(game.o_Frog_Reset), 1);
    txn("goal_done");

    // collision and goal together, then two more hits
    for (int h = 0; h < 3; h++) begin
      game.i_Collision = 1'b1;
      game.i_Frog_Y = (h == 0) ? 6'd0 : 6'd7;
      tick(1);
      game.i_Collision = 1'b0; game.i_Frog_Y = 6'd10;
      chk("hit_state", int'(game.o_State), 2);
      chk("hit_lives", int'(game.o_Lives), 2 - h);
      chk("hit_score", int'(game.o_Score), 1);
      txn("hit");
      tick(HOLD);
      chk("hit_exit_state", int'(game.o_State), (h == 2) ? 4 : 1);
      chk("hit_exit_fr",    int'(game.o_Frog_Reset), (h == 2) ? 0 : 1);
      txn("hit_done");
    end
    game.i_Collision = 1'b1; game.i_Frog_Y = 6'd0; tick(5);
    game.i_Collision = 1'b0; game.i_Frog_Y = 6'd10;
    chk("over_hold_state", int'(game.o_State), 4);
    chk("over_hold_score", int'(game.o_Score), 1);
    txn("over");

    // start held through reset
    game.i_Start = 1'b1; rst = 1'b1; tick(2);
    rst = 1'b0; tick(3);
    chk("held_start_state", int'(game.o_State), 0);
    txn("held_start");
    game.i_Start = 1'b0; tick(1);
    game.i_Start = 1'b1; tick(1);
    game.i_Start = 1'b0;
    chk("repress_state", int'(game.o_State), 1);
    txn("repress");

    // reset during second HIT cycle
    tick(1);
    game.i_Collision = 1'b1; tick(1);
    game.i_Collision = 1'b0; tick(1);
    chk("midhit_state", int'(game.o_State), 2);
    rst = 1'b1; tick(1);
    chk("midhit_rst_state", int'(game.o_State), 0);
    chk("midhit_rst_lives", int'(game.o_Lives), 0);
    chk("midhit_rst_fr",    int'(game.o_Frog_Reset), 0);
    txn("midhit_rst");
    rst = 1'b0; tick(1);

    // score and level saturation
    game.i_Start = 1'b1; tick(1);
    game.i_Start = 1'b0;
    for (int g = 0; g < 260; g++) begin
      game.i_Frog_Y = 6'd0; tick(1);
      game.i_Frog_Y = 6'd10; tick(HOLD);
    end
    chk("sat_score", int'(game.o_Score), 255);
    chk("sat_level", int'(game.o_Level), MAXLVL);
    txn("saturate");

    // randomized play
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 149) == 0);
      game.i_Start = ($urandom_range(0, 7) == 0);
      game.i_Collision = ($urandom_range(0, 5) == 0);
      game.i_Frog_Y = ($urandom_range(0, 4) == 0) ? 6'd0 : 6'($urandom_range(1, 29));
      tick(1);
    end
    rst = 1'b0;
    txn("random_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
